regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with an in-block busy scoreboard, write-to-read bypass and a post-reset clearing sweep. It sits between decode/issue and writeback of the pipelined core. Decode reads operands and reserves destination registers through this block. Writeback writes results and releases those reservations.

## Interface
Parameters:
- XLEN, 64: data width of every register.
- AW, 5: register address width; NREGS = 2**AW registers.
- INIT_REG, 11: index preloaded by the clearing sweep; 0 disables the preload.
- INIT_VAL, 8: value written to INIT_REG by the sweep.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ready  out  1  high once the clearing sweep is complete.
- rs1, rs2  in  AW each  read addresses.
- rdata1, rdata2  out  XLEN each  read data; combinational.
- busy1, busy2  out  1 each  rs1/rs2 pending-write flags; combinational.
- rsv_en  in  1  reserve request for rsv_addr.
- rsv_addr  in  AW  destination register being issued.
- we  in  1  writeback write enable.
- waddr  in  AW  writeback destination.
- wdata  in  XLEN  writeback data.

## Operation
- Register 0 always reads as 0 and never reports busy.
  - Writes to register 0 are dropped.
  - Reserves of register 0 are dropped.
- FSM states:
  - INIT: entered on any cycle with reset high, including mid-sweep or mid-RUN; counter cnt is forced to 0.
  - INIT, reset low: each edge writes reg[cnt] = (cnt == INIT_REG && INIT_REG != 0) ? INIT_VAL : 0, then cnt increments.
  - INIT exit: on the edge that clears reg[NREGS-1], the FSM moves to RUN.
  - RUN: remains until reset.
- In INIT:
  - ready = 0.
  - rdata1/2 = 0 and busy1/2 = 0.
  - we and rsv_en are ignored.
  - The busy vector is held at all-zero.
- In RUN, write: reg[waddr] = wdata on the edge when we = 1 and waddr != 0.
- In RUN, read:
  - rdataN = (we && waddr == rsN && rsN != 0) ? wdata : reg[rsN] (write-first bypass).
  - rsN == 0 returns 0.
- Scoreboard, evaluated per edge in RUN:
  - Set: busy[rsv_addr] is set when rsv_en = 1 and rsv_addr != 0.
  - Clear: busy[waddr] is cleared when we = 1.
  - Same register hit by both in one cycle: the set wins and busy stays 1, because the reservation belongs to the younger instruction.
  - Set and clear on different registers in one cycle: both take effect.
  - A write to a register that is not busy is legal; busy stays 0.
- Busy output: busyN = busy[rsN] & ~(we && waddr == rsN). A register completing writeback this cycle therefore reads not-busy with bypassed data.
- Reset mid-operation:
  - The next edge clears all busy bits and returns the FSM to INIT.
  - Register contents are not guaranteed until the sweep finishes.

## Timing
- Reset values:
  - ready = 0, cnt = 0, busy vector = 0.
  - rdata1/2 = 0, busy1/2 = 0.
- Sweep length: exactly NREGS edges with reset low.
- ready rises after the NREGS-th such edge: 32 cycles at AW = 5.
- Read latency: 0 cycles (combinational from rs1/rs2, we, waddr, wdata).
- Write latency: 1 edge; a plain read sees the stored value the cycle after the write.
- Reserve latency: 1 edge; busyN reflects a reservation the cycle after rsv_en.
- No backpressure; every request in RUN is accepted in the cycle it is presented.
- Expected size: roughly 150-250 lines of RTL.

## Test plan
- Reset sweep:
  - Stimulus: reset high 3 cycles, then low.
  - Response: ready = 0 for 32 edges, then 1.
  - Then rs1 = 11 -> rdata1 = 8; rs2 = 5 -> rdata2 = 0.
  - A we = 1 pulse during the sweep has no effect.
- Write/read/bypass:
  - Stimulus: RUN, we = 1, waddr = 7, wdata = 0xDEAD_BEEF_0000_0001, rs1 = 7.
  - Response: rdata1 equals wdata in the same cycle.
  - Next cycle with we = 0: rdata1 is unchanged.
- Register 0:
  - Stimulus: we = 1, waddr = 0, wdata = all-ones; then rsv_en = 1, rsv_addr = 0; rs1 = 0.
  - Response: rdata1 = 0 and busy1 = 0 throughout.
- Scoreboard lifecycle:
  - rsv_en, rsv_addr = 4 -> busy1 = 1 next cycle (rs1 = 4).
  - Later we, waddr = 4 -> busy1 = 0 in that same cycle, rdata1 = wdata; busy stays 0 afterwards.
- Simultaneous reserve and writeback:
  - Same register: busy[9] = 1; rsv_en with rsv_addr = 9 and we with waddr = 9 in one cycle -> next cycle busy1 = 1 (rs1 = 9), reg[9] = wdata.
  - Different registers: rsv 3 and write 9 together -> busy[3] = 1, busy[9] = 0.
- Reset mid-operation:
  - Stimulus: in RUN with busy[4] = 1 and reg[7] nonzero, reset for 1 cycle.
  - Response: ready = 0, busy1 = 0, and the sweep restarts from cnt = 0.
  - After 32 edges: reg[7] = 0, reg[11] = 8, ready = 1.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard, write-first bypass
// and a post-reset sweep that clears every register and optionally preloads one.
//
// state   | meaning
// ST_INIT | clearing sweep in progress; reads/busy forced to 0, requests ignored
// ST_RUN  | normal operation; reads, writes and reservations accepted
module regfile_sb #(
    parameter int XLEN     = 64,
    parameter int AW       = 5,
    parameter int INIT_REG = 11,
    parameter int INIT_VAL = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic            o_ready,
    input  logic [AW-1:0]   i_rs1,
    input  logic [AW-1:0]   i_rs2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    output logic            o_busy1,
    output logic            o_busy2,
    input  logic            i_rsv_en,
    input  logic [AW-1:0]   i_rsv_addr,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    localparam int NREGS = 2 ** AW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;

    logic              w_run;
    logic              w_sweep_last;
    logic [XLEN-1:0]   w_sweep_val;
    logic              w_wr_ok;
    logic [NREGS-1:0]  w_set_mask;
    logic [NREGS-1:0]  w_clr_mask;
    logic              w_hit1;
    logic              w_hit2;

    assign w_run        = (r_state == ST_RUN);
    assign w_sweep_last = (r_cnt == AW'(NREGS - 1));
    assign w_sweep_val  = ((INIT_REG != 0) && (r_cnt == AW'(INIT_REG))) ? XLEN'(INIT_VAL) : '0;
    assign w_wr_ok      = w_run && i_we && (i_waddr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_sweep_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_run) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

    // Storage has no reset; the sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!w_run) begin
                r_regs[r_cnt] <= w_sweep_val;
            end else if (w_wr_ok) begin
                r_regs[i_waddr] <= i_wdata;
            end
        end
    end

    // Set is applied after clear so a same-register reserve+writeback stays busy.
    assign w_set_mask = (i_rsv_en && (i_rsv_addr != '0)) ? (NREGS'(1) << i_rsv_addr) : '0;
    assign w_clr_mask = i_we ? (NREGS'(1) << i_waddr) : '0;

    always_ff @(posedge clk) begin
        if (reset || !w_run) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign w_hit1 = i_we && (i_waddr == i_rs1);
    assign w_hit2 = i_we && (i_waddr == i_rs2);

    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        o_busy1  = 1'b0;
        o_busy2  = 1'b0;
        if (w_run) begin
            if (i_rs1 != '0) begin
                o_rdata1 = w_hit1 ? i_wdata : r_regs[i_rs1];
                o_busy1  = r_busy[i_rs1] & ~w_hit1;
            end
            if (i_rs2 != '0) begin
                o_rdata2 = w_hit2 ? i_wdata : r_regs[i_rs2];
                o_busy2  = r_busy[i_rs2] & ~w_hit2;
            end
        end
    end

    assign o_ready = w_run;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected outputs are queued when stimulus is
// applied and popped/compared shortly after, away from the clock edge.
module tb_regfile_sb;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic            clk;
    logic            reset;
    logic            o_ready;
    logic [AW-1:0]   i_rs1, i_rs2;
    logic [XLEN-1:0] o_rdata1, o_rdata2;
    logic            o_busy1, o_busy2;
    logic            i_rsv_en;
    logic [AW-1:0]   i_rsv_addr;
    logic            i_we;
    logic [AW-1:0]   i_waddr;
    logic [XLEN-1:0] i_wdata;

    regfile_sb #(.XLEN(XLEN), .AW(AW), .INIT_REG(11), .INIT_VAL(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .o_ready    (o_ready),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .o_rdata1   (o_rdata1),
        .o_rdata2   (o_rdata2),
        .o_busy1    (o_busy1),
        .o_busy2    (o_busy2),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_addr (i_rsv_addr),
        .i_we       (i_we),
        .i_waddr    (i_waddr),
        .i_wdata    (i_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_RD1 = 0, S_RD2 = 1, S_BS1 = 2, S_BS2 = 3, S_RDY = 4;

    typedef struct {
        string           tag;
        int              sel;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [XLEN-1:0] observe(input int sel);
        case (sel)
            S_RD1:   return o_rdata1;
            S_RD2:   return o_rdata2;
            S_BS1:   return XLEN'(o_busy1);
            S_BS2:   return XLEN'(o_busy2);
            default: return XLEN'(o_ready);
        endcase
    endfunction

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [XLEN-1:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic compare_all();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic idle();
        i_we     = 1'b0;
        i_rsv_en = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; i_rs1 = 5'd11; i_rs2 = 5'd5;
        i_rsv_en = 1'b0; i_rsv_addr = '0; i_we = 1'b0; i_waddr = '0; i_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_out("rst_ready", S_RDY, 0);
        expect_out("rst_rdata1", S_RD1, 0);
        expect_out("rst_busy1", S_BS1, 0);
        compare_all();

        // Sweep: count edges to ready; requests late in the sweep must be ignored.
        reset = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 20) begin
                expect_out("sweep_rdata1_gated", S_RD1, 0);
                expect_out("sweep_ready_low", S_RDY, 0);
                compare_all();
            end
            if (n == 27) begin
                i_we = 1'b1; i_waddr = 5'd11; i_wdata = '1;
                i_rsv_en = 1'b1; i_rsv_addr = 5'd5;
            end
            if (n == 31) idle();
        end while (!o_ready && n < 100);
        check("sweep_len", XLEN'(n), 32);

        @(negedge clk);
        i_rs1 = 5'd11; i_rs2 = 5'd5;
        expect_out("preload_r11", S_RD1, 8);
        expect_out("cleared_r5", S_RD2, 0);
        expect_out("no_rsv_in_init", S_BS2, 0);
        expect_out("ready_high", S_RDY, 1);
        compare_all();

        @(negedge clk);
        i_we = 1'b1; i_waddr = 5'd7; i_wdata = 64'hDEAD_BEEF_0000_0001; i_rs1 = 5'd7;
        expect_out("bypass_r7", S_RD1, 64'hDEAD_BEEF_0000_0001);
        compare_all();
        @(negedge clk);
        idle();
        expect_out("stored_r7", S_RD1, 64'hDEAD_BEEF_0000_0001);
        compare_all();

        @(negedge clk);
        i_we = 1'b1; i_waddr = 5'd0; i_wdata = '1; i_rs1 = 5'd0; i_rs2 = 5'd0;
        expect_out("r0_wr_rd1", S_RD1, 0);
        expect_out("r0_wr_rd2", S_RD2, 0);
        compare_all();
        @(negedge clk);
        idle(); i_rsv_en = 1'b1; i_rsv_addr = 5'd0;
        expect_out("r0_rsv_rd1", S_RD1, 0);
        expect_out("r0_rsv_bs1", S_BS1, 0);
        compare_all();
        @(negedge clk);
        idle();
        expect_out("r0_after_rd1", S_RD1, 0);
        expect_out("r0_after_bs1", S_BS1, 0);
        compare_all();

        @(negedge clk);
        i_rsv_en = 1'b1; i_rsv_addr = 5'd4; i_rs1 = 5'd4;
        expect_out("rsv4_same_cycle", S_BS1, 0);
        compare_all();
        @(negedge clk);
        idle();
        expect_out("rsv4_busy", S_BS1, 1);
        compare_all();
        @(negedge clk);
        i_we = 1'b1; i_waddr = 5'd4; i_wdata = 64'h1234;
        expect_out("wb4_busy_masked", S_BS1, 0);
        expect_out("wb4_bypass", S_RD1, 64'h1234);
        compare_all();
        @(negedge clk);
        idle();
        expect_out("wb4_busy_clear", S_BS1, 0);
        expect_out("wb4_stored", S_RD1, 64'h1234);
        compare_all();

        @(negedge clk);
        i_rsv_en = 1'b1; i_rsv_addr = 5'd9; i_rs1 = 5'd9;
        compare_all();
        @(negedge clk);
        i_rsv_en = 1'b1; i_rsv_addr = 5'd9; i_we = 1'b1; i_waddr = 5'd9; i_wdata = 64'h99;
        expect_out("same9_busy_masked", S_BS1, 0);
        expect_out("same9_bypass", S_RD1, 64'h99);
        compare_all();
        @(negedge clk);
        idle();
        expect_out("same9_set_wins", S_BS1, 1);
        expect_out("same9_stored", S_RD1, 64'h99);
        compare_all();

        @(negedge clk);
        i_rsv_en = 1'b1; i_rsv_addr = 5'd3; i_we = 1'b1; i_waddr = 5'd9; i_wdata = 64'h77;
        i_rs1 = 5'd3; i_rs2 = 5'd9;
        expect_out("diff_bs2_masked", S_BS2, 0);
        expect_out("diff_rd2_bypass", S_RD2, 64'h77);
        compare_all();
        @(negedge clk);
        idle();
        expect_out("diff_busy3", S_BS1, 1);
        expect_out("diff_busy9_clr", S_BS2, 0);
        expect_out("diff_r9", S_RD2, 64'h77);
        compare_all();

        @(negedge clk);
        i_rsv_en = 1'b1; i_rsv_addr = 5'd31; i_rs1 = 5'd31;
        compare_all();
        @(negedge clk);
        idle();
        expect_out("rsv31_busy", S_BS1, 1);
        compare_all();
        @(negedge clk);
        i_we = 1'b1; i_waddr = 5'd31; i_wdata = 64'h31;
        compare_all();
        @(negedge clk);
        idle();
        expect_out("wb31_clear", S_BS1, 0);
        expect_out("wb31_stored", S_RD1, 64'h31);
        compare_all();

        @(negedge clk);
        i_rsv_en = 1'b1; i_rsv_addr = 5'd4;
        compare_all();
        @(negedge clk);
        idle(); i_rs1 = 5'd4; i_rs2 = 5'd7;
        expect_out("pre_rst_busy4", S_BS1, 1);
        expect_out("pre_rst_r7", S_RD2, 64'hDEAD_BEEF_0000_0001);
        compare_all();

        @(negedge clk);
        reset = 1'b1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        expect_out("midrst_ready", S_RDY, 0);
        expect_out("midrst_busy1", S_BS1, 0);
        expect_out("midrst_rd2", S_RD2, 0);
        compare_all();

        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!o_ready && n < 100);
        check("resweep_len", XLEN'(n), 32);

        @(negedge clk);
        i_rs1 = 5'd7; i_rs2 = 5'd11;
        expect_out("resweep_r7", S_RD1, 0);
        expect_out("resweep_r11", S_RD2, 8);
        expect_out("resweep_ready", S_RDY, 1);
        compare_all();
        @(negedge clk);
        i_rs1 = 5'd4;
        expect_out("resweep_busy4", S_BS1, 0);
        expect_out("resweep_r4", S_RD1, 0);
        compare_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
